i2c_slave_resp: RTL and testbench
=================================

Name: i2c_slave_resp

Overview:
- Byte-level I2C target (responder), the far end of the bus driven by the I2C master core.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it, then delivers received bytes or fetches bytes to transmit through a simple pulse/data interface.
- Only drives SDA, and only as an open-drain pull-low enable; never drives SCL (no clock stretching).

Parameters:
- ADDR, 7'h50, 7-bit target address this block responds to.
- FILT_LEN, 3, number of consecutive equal samples required before a filtered SCL/SDA level changes (glitch filter), 1..7.

Ports:
- clk  in  1  system clock; must be ≥ 20× SCL frequency.
- reset_n  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL pad input.
- sda_i  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- rx_data  out  8  last byte written by the master; valid when rx_valid = 1, held until the next byte.
- rx_valid  out  1  one-clk pulse per received data byte.
- tx_data  in  8  byte to send to the master; sampled on the clk following tx_req.
- tx_req  out  1  one-clk pulse requesting the next read byte.
- busy  out  1  high from an address match until STOP, or until a mismatch returns to IDLE.
- rw  out  1  R/W bit of the current transfer (1 = master read).

Behaviour:
- Reset (async, reset_n = 0):
  - Outputs: sda_oe = 0, rx_data = 0, rx_valid = 0, tx_req = 0, busy = 0, rw = 0.
  - State IDLE.
  - Filtered SCL and SDA registers = 1.
- Input conditioning:
  - 2-FF synchronizer, then FILT_LEN filter, then one-clk edge flags: scl_rise, scl_fall, sda_rise, sda_fall.
  - Latency from pad to edge flag: 2 + FILT_LEN clk.
- Bus conditions:
  - START = sda_fall while filtered SCL = 1.
  - STOP = sda_rise while filtered SCL = 1.
  - Both take priority over all state activity.
  - START in any state: bit counter = 0, sda_oe = 0, state ADDR.
  - STOP in any state: sda_oe = 0, busy = 0, state IDLE.
- Bit timing:
  - Shift in MSB first on scl_rise.
  - Change sda_oe only on scl_fall.
  - 3-bit bit counter; wraps 7→0 at the end of each byte.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th scl_rise, compare [7:1] with ADDR and latch rw = bit0.
    - Match: at the next scl_fall assert sda_oe (ACK), set busy, go ADDR_ACK.
    - Mismatch: go IDLE, sda_oe stays 0.
  - ADDR_ACK: at the scl_fall ending the ACK:
    - rw = 0: release SDA, go WR_DATA.
    - rw = 1: pulse tx_req on that clk, load tx_data into the shift register on the following clk, drive MSB (sda_oe = ~bit7) on that same clk, go RD_DATA.
  - WR_DATA: after the 8th scl_rise, update rx_data and pulse rx_valid 1 clk later. At the next scl_fall assert sda_oe (ACK always given), go WR_ACK.
  - WR_ACK: at scl_fall release SDA, go WR_DATA.
  - RD_DATA: present bits 6..0 at successive scl_fall. After the 8th bit's scl_fall release SDA, go RD_ACK.
  - RD_ACK: sample SDA at scl_rise.
    - 0 (master ACK): at scl_fall pulse tx_req, load and drive the next byte, go RD_DATA.
    - 1 (NACK): go WAIT_STOP.
  - WAIT_STOP: sda_oe = 0; wait for STOP or repeated START.
- Repeated START mid-byte: partial byte discarded, no rx_valid.
- tx_data not updated in time: whatever is present is sent; no error flag.

Optional Feature:
- Macro I2C_GEN_CALL_EN.
- Defined: address byte 8'h00 (general call, W) is also ACKed. rw = 0, following bytes flow through WR_DATA exactly as for ADDR. 8'h01 is ignored.
- Undefined: 8'h00 is a mismatch and returns to IDLE with no ACK.

Decomposition:
- Shared package i2c_pkg: state encoding enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP), GEN_CALL_ADDR = 7'h00, RW_READ = 1'b1.
- Sub-module i2c_line_filter: sync + FILT_LEN filter + edge flags. Instantiated twice (SCL, SDA).

Test Plan:
- Write 0xA0 then 0x3C, 0xFF, then STOP → ACK on address and both data bytes; rx_valid pulses twice with rx_data 0x3C then 0xFF; busy 1→0 after STOP.
- Address 0xA2 (0x51 W) → no ACK, busy stays 0, no rx_valid, state IDLE.
- Read 0xA1 with tx_data = 0x96, then 0x5A, master ACK then NACK, STOP → tx_req pulses twice; SDA carries 0x96, 0x5A; sda_oe 0 after NACK.
- Write 0xA0, 0x12, repeated START, 0xA1, read 1 byte → rx_valid for 0x12 only; rw becomes 1; tx_req pulses once.
- 1-clk SDA glitch low while SCL high during idle, FILT_LEN = 3 → no START detected, state remains IDLE.
- reset_n low mid-RD_DATA with sda_oe = 1 → sda_oe, busy, tx_req = 0 immediately (async); next START is processed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C target blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam logic       RW_READ       = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer, FILT_LEN-sample glitch filter and
// one-clk rise/fall flags for one open-drain bus line (idles high).
// Pad-to-flag latency is 2 + FILT_LEN clk; the flags coincide with the
// filtered level change.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [2:0] FILT_TC = 3'(FILT_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, rise_q, fall_q;
  logic [2:0] cnt_q;

  // Down-counter reloads whenever the synced sample agrees with the filtered level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= FILT_TC;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= FILT_TC;
      end else if (cnt_q == 3'd0) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= FILT_TC;
      end else begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_resp.sv
// i2c_slave_resp: byte-level I2C target. Oversamples SCL/SDA, ACKs address
// ADDR, hands received bytes out on rx_data/rx_valid and fetches read bytes
// via tx_req/tx_data. Drives SDA only as an open-drain pull-low enable.
// Build option: define I2C_GEN_CALL_EN to also ACK the general-call write
// address (byte 8'h00).
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | bus free or not addressed; wait for START
// ST_ADDR      | shifting address byte; ACK pending after a match
// ST_ADDR_ACK  | driving address ACK
// ST_WR_DATA   | shifting a write byte from the master
// ST_WR_ACK    | driving data ACK
// ST_RD_DATA   | driving a read byte, MSB first
// ST_RD_ACK    | released SDA, sampling master ACK/NACK
// ST_WAIT_STOP | master NACKed; wait for STOP or repeated START
module i2c_slave_resp
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       rw
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .reset_n(reset_n), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .reset_n(reset_n), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d;
  logic       ack_pend_q, ack_pend_d;
  logic [7:0] byte_in;
  logic       addr_match;

  // Byte as it stands once the current SCL rise is shifted in, and address decode.
  always_comb begin
    byte_in    = {shift_q[6:0], sda_lvl};
    addr_match = (byte_in[7:1] == ADDR);
`ifdef I2C_GEN_CALL_EN
    if (byte_in == {GEN_CALL_ADDR, 1'b0}) addr_match = 1'b1;
`endif
  end

  // Next-state logic; bus conditions override everything, then a pending tx load.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    load_d     = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    ack_pend_d = ack_pend_q;
    if (start_det) begin
      state_d    = ST_ADDR;
      bitcnt_d   = 3'd0;
      sda_oe_d   = 1'b0;
      ack_pend_d = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ack_pend_d = 1'b0;
    end else if (load_q) begin
      shift_d  = tx_data;
      sda_oe_d = ~tx_data[7];
      bitcnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rw_d = byte_in[0];
              if (addr_match) begin
                ack_pend_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b1;
            busy_d     = 1'b1;
            state_d    = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = 3'd0;
            if (rw_q == RW_READ) begin
              tx_req_d = 1'b1;
              load_d   = 1'b1;
              state_d  = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              ack_pend_d = 1'b1;
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b1;
            state_d    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 3'd0;
              state_d  = ST_RD_ACK;
            end else begin
              // Rotate rather than shift so the spent MSB stays in the register.
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_lvl) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            tx_req_d = 1'b1;
            load_d   = 1'b1;
            state_d  = ST_RD_DATA;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        ST_IDLE:      sda_oe_d = 1'b0;
        default:      state_d  = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign rw       = rw_q;

endmodule

// File: tb/tb_i2c_slave_resp.sv
// tb_i2c_slave_resp: bit-banged I2C master driving the target, with a
// transaction-level expectation model (who ACKs, which bytes arrive, how
// many read requests) and randomized write/read transactions.
module tb_i2c_slave_resp;

  localparam int H = 20;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy, rw;
  logic [7:0] rx_data, tx_data;

  int         n_tests, n_fail;
  int         tx_req_cnt = 0;
  logic [7:0] rx_log [$];
  logic [7:0] xb [4];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_resp #(.ADDR(7'h50), .FILT_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  // Record delivered bytes and read requests.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back(rx_data);
    if (tx_req === 1'b1) tx_req_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit addr_acks(input logic [7:0] a);
    bit hit;
    hit = (a[7:1] == 7'h50);
`ifdef I2C_GEN_CALL_EN
    if (a == 8'h00) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wclk(H/2);
    m_scl = 1'b1; wclk(H);
    m_sda = 1'b0; wclk(H);
    m_scl = 1'b0; wclk(H/2);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wclk(H/2);
    m_scl = 1'b1; wclk(H);
    m_sda = 1'b1; wclk(H);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;    wclk(H/2);
    m_scl = 1'b1; wclk(H/2);
    s = sda_bus;  wclk(H/2);
    m_scl = 1'b0; wclk(H/2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    tx_data = next_tx;
    clock_bit(nack, s);
  endtask

  task automatic do_write(input logic [7:0] addr, input int n, input bit do_stop);
    logic ack;
    bit   exp_ack;
    int   rx0;
    rx0     = rx_log.size();
    exp_ack = addr_acks(addr);
    bus_start();
    write_byte(addr, ack);
    chk_val("wr_addr_ack", 32'(ack), 32'(exp_ack));
    chk_val("wr_busy", 32'(busy), 32'(exp_ack));
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        write_byte(xb[i], ack);
        chk_val("wr_data_ack", 32'(ack), 32'd1);
      end
    end
    if (do_stop) begin
      bus_stop();
      chk_val("busy_after_stop", 32'(busy), 32'd0);
    end
    chk_val("rx_count", 32'(rx_log.size() - rx0), exp_ack ? 32'(n) : 32'd0);
    for (int i = 0; i < n; i++)
      if (exp_ack && (rx0 + i < rx_log.size()))
        chk_val("rx_byte", 32'(rx_log[rx0 + i]), 32'(xb[i]));
  endtask

  task automatic do_read(input logic [7:0] addr, input int n, input bit do_stop);
    logic       ack;
    logic [7:0] v;
    bit         exp_ack;
    int         tq0;
    tq0     = tx_req_cnt;
    exp_ack = addr_acks(addr);
    tx_data = xb[0];
    bus_start();
    write_byte(addr, ack);
    chk_val("rd_addr_ack", 32'(ack), 32'(exp_ack));
    chk_val("rd_busy", 32'(busy), 32'(exp_ack));
    if (exp_ack) begin
      chk_val("rd_rw", 32'(rw), 32'd1);
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, (i + 1 < n) ? xb[i + 1] : 8'h00, v);
        chk_val("rd_byte", 32'(v), 32'(xb[i]));
      end
      chk_val("oe_after_nack", 32'(sda_oe), 32'd0);
    end
    chk_val("tx_req_count", 32'(tx_req_cnt - tq0), exp_ack ? 32'(n) : 32'd0);
    if (do_stop) begin
      bus_stop();
      chk_val("busy_after_stop", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] a;
    int         rx0, tq0, n;
    n_tests = 0;
    n_fail  = 0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    tx_data = 8'h00;
    reset_n = 1'b0;
    wclk(3);
    chk_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk_val("rst_rx_data", 32'(rx_data), 32'd0);
    chk_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk_val("rst_tx_req", 32'(tx_req), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_rw", 32'(rw), 32'd0);
    reset_n = 1'b1;
    wclk(10);

    // Write two bytes to our address.
    xb = '{8'h3C, 8'hFF, 8'h00, 8'h00};
    do_write(8'hA0, 2, 1'b1);

    // Foreign address: ignored.
    xb = '{8'h55, 8'h00, 8'h00, 8'h00};
    do_write(8'hA2, 1, 1'b1);

    // Read two bytes, ACK then NACK.
    xb = '{8'h96, 8'h5A, 8'h00, 8'h00};
    do_read(8'hA1, 2, 1'b1);

    // Write one byte, partial byte, repeated START into a one-byte read.
    xb = '{8'h12, 8'h00, 8'h00, 8'h00};
    rx0 = rx_log.size();
    tq0 = tx_req_cnt;
    do_write(8'hA0, 1, 1'b0);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    xb = '{8'hC3, 8'h00, 8'h00, 8'h00};
    do_read(8'hA1, 1, 1'b1);
    chk_val("rs_rx_count", 32'(rx_log.size() - rx0), 32'd1);
    chk_val("rs_tx_req_count", 32'(tx_req_cnt - tq0), 32'd1);
    chk_val("rs_rw", 32'(rw), 32'd1);

    // One-clk SDA glitch while SCL high must not look like START.
    wclk(10);
    rx0 = rx_log.size();
    m_sda = 1'b0; wclk(1);
    m_sda = 1'b1; wclk(20);
    chk_val("glitch_busy", 32'(busy), 32'd0);
    m_scl = 1'b0; wclk(H/2);
    write_byte(8'hA0, ack);
    chk_val("glitch_no_ack", 32'(ack), 32'd0);
    bus_stop();
    chk_val("glitch_rx_count", 32'(rx_log.size() - rx0), 32'd0);

    // Async reset while driving a read byte, then a normal write.
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    chk_val("rst_rd_addr_ack", 32'(ack), 32'd1);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    chk_val("rst_pre_oe", 32'(sda_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_val("rst_async_oe", 32'(sda_oe), 32'd0);
    chk_val("rst_async_busy", 32'(busy), 32'd0);
    chk_val("rst_async_tx_req", 32'(tx_req), 32'd0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wclk(10);
    reset_n = 1'b1;
    wclk(10);
    xb = '{8'h7E, 8'h00, 8'h00, 8'h00};
    do_write(8'hA0, 1, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
      else                           a = {7'h50, 1'($urandom_range(0, 1))};
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) xb[i] = 8'($urandom_range(0, 255));
      if (a[0]) do_read(a, n, 1'b1);
      else      do_write(a, n, 1'b1);
      wclk($urandom_range(5, 30));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
